regfile_multiport: RTL and testbench

Parametrised integer register file for the pipelined cores. It generalises width, depth and read-port count, and writes on the rising edge instead of the falling edge. It adds a synchronous reset that sequentially clears the array with a `busy` indication, plus optional write-to-read bypass. Register 0 is hardwired to zero; the file sits between the decode stage (read ports) and the writeback stage (write port).

---
 rtl/regfile_multiport.sv | 94 +++++++++
 tb/tb_regfile_multiport.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-read-port register file with sweep clear
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we3,
  input  logic [AW-1:0]       a3,
  input  logic [XLEN-1:0]     wd3,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic                busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic [XLEN-1:0]   rf_d [NREGS];
  logic              wr_req;

  assign busy   = (state_q == ST_CLEAR);
  assign wr_req = (state_q == ST_READY) && we3 && (a3 != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rf_d    = rf_q;
    if (!reset) begin
      unique case (state_q)
        ST_CLEAR: begin
          rf_d[idx_q] = '0;
          idx_d       = idx_q + AW'(1);
          if (idx_q == AW'(NREGS - 1)) begin
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (wr_req) begin
            rf_d[a3] = wd3;
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
    // Location 0 is constant so its storage folds away.
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    logic          byp_k;

    assign ra_k = ra[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    assign byp_k = wr_req && (a3 == ra_k);
`else
    assign byp_k = 1'b0;
`endif

    always_comb begin
      rd[k*XLEN +: XLEN] = rf_q[ra_k];
      if (busy || (ra_k == '0)) begin
        rd[k*XLEN +: XLEN] = '0;
      end else if (byp_k) begin
        rd[k*XLEN +: XLEN] = wd3;
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - randomized reference-model bench for regfile_multiport
module tb_regfile_multiport;

  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        busy;

  logic         we2;
  logic [3:0]   a2;
  logic [63:0]  wd2;
  logic [15:0]  ra2;
  logic [255:0] rd2;
  logic         busy2;

  regfile_multiport dut (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
    .ra(ra), .rd(rd), .busy(busy)
  );

  regfile_multiport #(.XLEN(64), .NREGS(16), .NRD(4)) dut2 (
    .clk(clk), .reset(reset), .we3(we2), .a3(a2), .wd3(wd2),
    .ra(ra2), .rd(rd2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_rf [NREGS];
  logic        m_busy = 1'b1;
  int          m_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (m_busy || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && a3 != 5'd0 && a3 == addr) return wd3;
`endif
    return m_rf[addr];
  endfunction

  // One rising edge; the model applies the rules to the inputs presented before it.
  task automatic tick();
    logic        r = reset;
    logic        w = !m_busy && !reset && we3 && (a3 != 5'd0);
    logic [4:0]  wa = a3;
    logic [31:0] wdat = wd3;
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 1'b1;
      m_left = NREGS - 1;
      for (int i = 0; i < NREGS; i++) m_rf[i] = 32'd0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else if (w) begin
      m_rf[wa] = wdat;
    end
  endtask

  task automatic check_reads(input string tag);
    #2;
    check({tag, "_p0"}, {32'd0, rd[31:0]},  {32'd0, exp_rd(ra[4:0])});
    check({tag, "_p1"}, {32'd0, rd[63:32]}, {32'd0, exp_rd(ra[9:5])});
  endtask

  // Counts edges after reset release until both busy flags drop.
  task automatic sweep(output int f1, output int f2, input bit poke_x3);
    f1 = 0;
    f2 = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke_x3 && i == 5) begin
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'hAA;
      end else begin
        we3 = 1'b0;
      end
      tick();
      if (!busy && f1 == 0) f1 = i;
      if (!busy2 && f2 == 0) f2 = i;
    end
    we3 = 1'b0;
  endtask

  int f1, f2;

  initial begin
    reset = 1'b1; we3 = 1'b0; a3 = '0; wd3 = '0; ra = '0;
    we2 = 1'b0; a2 = '0; wd2 = '0; ra2 = '0;
    for (int i = 0; i < NREGS; i++) m_rf[i] = 32'd0;

    repeat (3) tick();
    check("busy_in_reset", {63'd0, busy}, 64'd1);
    check("busy2_in_reset", {63'd0, busy2}, 64'd1);
    ra = {5'd9, 5'd4};
    check_reads("rd_in_reset");
    check("rd2_in_reset", rd2[63:0], 64'd0);

    reset = 1'b0;
    sweep(f1, f2, 1'b1);
    check("sweep_len", 64'(f1), 64'd31);
    check("sweep_len2", 64'(f2), 64'd15);
    check("busy_model", {63'd0, busy}, {63'd0, m_busy});

    for (int a = 0; a < NREGS; a++) begin
      ra = {5'(a), 5'(NREGS - 1 - a)};
      check_reads("clear_rd");
    end
    ra = {5'd3, 5'd3};
    check("x3_dropped", {32'd0, rd[31:0]}, 64'd0);

    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0;
    ra = {5'd5, 5'd5};
    check_reads("x5");
    check("x5_const", {32'd0, rd[63:32]}, 64'hDEADBEEF);

    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
    tick();
    we3 = 1'b0;
    ra = {5'd5, 5'd0};
    check_reads("x0");
    check("x0_const", {32'd0, rd[31:0]}, 64'd0);

    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h12345678; ra = {5'd0, 5'd7};
    check_reads("byp_same");
`ifdef REGFILE_BYPASS_EN
    check("byp_const", {32'd0, rd[31:0]}, 64'h12345678);
`else
    check("byp_const", {32'd0, rd[31:0]}, 64'd0);
`endif
    tick();
    we3 = 1'b0;
    check_reads("byp_after");
    check("byp_after_const", {32'd0, rd[31:0]}, 64'h12345678);

    we2 = 1'b1; a2 = 4'd1; wd2 = 64'h1;
    tick();
    a2 = 4'd2; wd2 = 64'h2;
    tick();
    a2 = 4'd15; wd2 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we2 = 1'b0;
    ra2 = {4'd0, 4'd15, 4'd2, 4'd1};
    #2;
    check("p2_x1",  rd2[63:0],    64'h1);
    check("p2_x2",  rd2[127:64],  64'h2);
    check("p2_x15", rd2[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    check("p2_x0",  rd2[255:192], 64'd0);

    for (int c = 0; c < 400; c++) begin
      we3 = 1'($urandom_range(0, 1));
      a3  = 5'($urandom_range(0, NREGS - 1));
      wd3 = $urandom;
      ra  = {5'($urandom_range(0, NREGS - 1)),
             ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, NREGS - 1))};
      check_reads("rand");
      tick();
    end
    we3 = 1'b0;

    we3 = 1'b1; a3 = 5'd20; wd3 = 32'h55;
    tick();
    we3 = 1'b0;
    ra = {5'd0, 5'd20};
    check_reads("x20_pre");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (9) tick();
    check("busy_mid", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep(f1, f2, 1'b0);
    check("resweep_len", 64'(f1), 64'd31);
    check_reads("x20_post");
    check("x20_post_const", {32'd0, rd[31:0]}, 64'd0);
    ra2 = {4'd0, 4'd15, 4'd2, 4'd1};
    #1;
    check("p2_cleared", rd2[191:0], 192'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
